// File: rtl/chunk_serial_subtractor.sv
// chunk_serial_subtractor: computes d = a - b - bin over NCH = WIDTH/CHUNK cycles,
// one CHUNK-bit slice per clock, LSB chunk first, borrow carried in a register.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, bin); ready only while idle
//   out_valid/out_ready result handshake (d, bo, ovf); result held until taken
//   a, b, bin           minuend, subtrahend, borrow-in
//   d, bo               registered difference and borrow-out of the MSB
//   ovf                 signed overflow, only when SUB_OVERFLOW_EN is defined
//
// Optional feature macro: SUB_OVERFLOW_EN (adds ovf port and its logic).
module chunk_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [IW-1:0]    idx;
    logic [CHUNK:0]   diff;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operands shift right each CALC cycle, so the live chunk is always
    // the low CHUNK bits. The top bit of the CHUNK+1 wide difference is
    // the borrow out of this slice.
    always_comb begin
        diff = {1'b0, a_q[CHUNK-1:0]}
             - {1'b0, b_q[CHUNK-1:0]}
             - (CHUNK+1)'(brw_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            brw_q <= 1'b0;
            idx   <= '0;
            d     <= '0;
            bo    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        brw_q <= bin;
                        idx   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    d[idx*CHUNK +: CHUNK] <= diff[CHUNK-1:0];
                    brw_q <= diff[CHUNK];
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    if (idx == LAST) begin
                        bo    <= diff[CHUNK];
                        idx   <= '0;
                        state <= DONE;
`ifdef SUB_OVERFLOW_EN
                        // On the last slice a_q/b_q hold the operand MSBs.
                        // Overflow only when signs differ and the result
                        // sign departs from the minuend sign.
                        ovf <= (a_q[CHUNK-1] ^ b_q[CHUNK-1])
                             & (a_q[CHUNK-1] ^ diff[CHUNK-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
